// File: rtl/cla_share_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
package cla_share_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_share_arbiter_if.sv
// Requester-side word handshake and response slot of the shared adder.
interface cla_share_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import cla_share_arbiter_pkg::*;

  localparam int unsigned IW = id_width(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WORD_W-1:0] req_a;
  logic [NREQ*WORD_W-1:0] req_b;
  logic [NREQ-1:0]        req_sub;
  logic [NREQ-1:0]        req_last;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WORD_W-1:0]      rsp_sum;
  logic                   rsp_cout;
  logic                   rsp_ovf;
  logic [IW-1:0]          rsp_id;
  logic                   rsp_last;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, rsp_last
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, rsp_last
  );

endinterface

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: 4-bit groups with a group-level lookahead chain.
module CLA_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] p, g, c;
  logic [7:0]  gg, gp;
  logic [8:0]  cg;

  // Bit and group propagate/generate, then carries into every bit.
  always_comb begin
    p = a_i ^ b_i;
    g = a_i & b_i;
    c = '0;
    cg = '0;
    cg[0] = cin_i;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      cg[j+1] = gg[j] | (gp[j] & cg[j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = cg[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
    end
    sum_o  = p ^ c;
    cout_o = cg[8];
  end

endmodule

// File: rtl/cla_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr_i wins (one-hot grant).
module cla_share_arbiter_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  // Scan requests in rotated order starting at the pointer.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cla_share_arbiter.sv
// Shares one CLA among NREQ requesters; locks the owner across multi-word ops.
module cla_share_arbiter
  import cla_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  cla_share_arbiter_if.slave bus
);

  localparam int unsigned IW = id_width(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;
  logic              rsp_last_q, rsp_last_d;

  logic [WORD_W-1:0] a_arr [NREQ];
  logic [WORD_W-1:0] b_arr [NREQ];
  logic [NREQ-1:0]   arb_gnt, ready;
  logic [IW-1:0]     arb_idx, sel_idx;
  logic              first, sel_valid, slot_free, accept, sub_eff, cin, last, ovf, cout;
  logic [WORD_W-1:0] op_a, op_b, sum;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[gi*WORD_W +: WORD_W];
    assign b_arr[gi] = bus.req_b[gi*WORD_W +: WORD_W];
  end

  cla_share_arbiter_rr_arbiter #(
    .N   (NREQ),
    .PtrW(IW)
  ) u_rr_arbiter (
    .req_i(bus.req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt)
  );

  CLA_32bit u_cla (
    .a_i   (op_a),
    .b_i   (op_b),
    .cin_i (cin),
    .sum_o (sum),
    .cout_o(cout)
  );

  // Grant selection and adder operand muxing; ready never looks at operands.
  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = IW'(i);
    end
    first     = (state_q == StIdle);
    sel_idx   = first ? arb_idx : owner_q;
    sel_valid = first ? (|bus.req_valid) : bus.req_valid[sel_idx];
    slot_free = !rsp_valid_q || bus.rsp_ready;
    accept    = sel_valid && slot_free;
    ready     = '0;
    if (accept) ready[sel_idx] = 1'b1;
    sub_eff = first ? bus.req_sub[sel_idx] : sub_q;
    cin     = first ? sub_eff : carry_q;
    op_a    = a_arr[sel_idx];
    op_b    = b_arr[sel_idx] ^ {WORD_W{sub_eff}};
    last    = bus.req_last[sel_idx];
    ovf     = (op_a[WORD_W-1] == op_b[WORD_W-1]) && (sum[WORD_W-1] != op_a[WORD_W-1]);
  end

  // Next-state: lock/unlock, carry chaining and response slot refill/drain.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    rsp_last_d  = rsp_last_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum;
      rsp_cout_d  = cout;
      rsp_ovf_d   = last && ovf;
      rsp_id_d    = sel_idx;
      rsp_last_d  = last;
      if (last) begin
        state_d  = StIdle;
        rr_ptr_d = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
      end else begin
        state_d = StLocked;
        owner_d = sel_idx;
        carry_d = cout;
        sub_d   = sub_eff;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule
